ifr_cnt_fsm: RTL and testbench
==============================

Name: ifr_cnt_fsm

Overview:
- Read-side counter and FSM for the input-feature row buffer. It is the consumer of the buffer that the write-side packing counter fills.
- Generates SRAM read enables and addresses, and inserts left/right zero-padding beats.
- Repeats a row for a programmed number of passes and presents beats to the PE array with a valid/ready handshake.
- Sits between the input-feature SRAM and the PE input mux. The mux selects zero when dout_pad is high.

Parameters:
- CNT00_WIDTH, 10, width of the column (beat-in-pass) counter
- CNT01_WIDTH, 10, width of the pass counter
- RS_ADDR_WIDTH, 10, SRAM read-address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- din_start  in  1  one-cycle start pulse, honoured only in RD_IDLE
- din_buf_ready  in  1  write side has a complete row in the buffer
- din_cfg_mast_state  in  3  1=LEFT, 2=NORMAL, 3=RIGH, other=NORMAL; sampled at start
- din_pe_ready  in  1  PE accepts the current beat
- rd_cnt00_finalnum  in  CNT00_WIDTH  data beats per pass minus 1
- rd_cnt01_finalnum  in  CNT01_WIDTH  passes minus 1
- rd_srad_finalnum  in  RS_ADDR_WIDTH  highest SRAM address; the address counter wraps after it
- dout_rd_curr_state  out  3  FSM state
- dout_sram_cen  out  1  SRAM read enable, combinational, high on data-beat issue
- dout_sram_addr  out  RS_ADDR_WIDTH  read address, equal to the srad counter
- dout_valid  out  1  beat valid toward the PE, registered
- dout_pad  out  1  current beat is zero-padding, registered alongside dout_valid
- dout_rd_last  out  1  current beat is the final beat of the final pass
- dout_rd_cnt00  out  CNT00_WIDTH  column counter
- dout_rd_cnt01  out  CNT01_WIDTH  pass counter
- dout_busy  out  1  state is not RD_IDLE
- dout_done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - State is RD_IDLE.
  - All counters, dout_valid, dout_pad, dout_rd_last, dout_done and the cfg register are 0.
  - Reset mid-operation aborts immediately; no further beats are issued.
- States:
  - RD_IDLE=0, RD_NORMAL=1, RD_LEFT=2, RD_RIGH=3, RD_DONE=4, RD_WAIT=5.
- Issue condition: issue = state in {LEFT, NORMAL, RIGH} & (!dout_valid | din_pe_ready).
  - LEFT and RIGH issues are pad beats; they do not assert cen and do not advance srad.
  - NORMAL issues are data beats; they assert cen and advance srad and cnt00.
- Output stage and latency:
  - dout_valid <= issue, else it clears when din_pe_ready is high, else it holds.
  - dout_pad and dout_rd_last load on issue.
  - SRAM read latency is 1 cycle, so the data beat appears with dout_valid one cycle after cen.
  - The SRAM holds its output while the beat is stalled, because no new cen is issued until the beat is accepted.
  - Throughput is 1 beat per cycle while din_pe_ready=1.
- Counters:
  - cnt00 increments on each data issue; it wraps to 0 on a data issue when cnt00 == rd_cnt00_finalnum.
  - cnt01 increments on each pass end and resets to 0 at start.
  - srad increments on each data issue, wraps to 0 after rd_srad_finalnum, and is not reset between passes.
  - srad resets to 0 only at reset and on start.
- Pass end: the last beat of a pass. That is the data issue with cnt00 at final for LEFT/NORMAL, or the RIGH pad issue for RIGH.
- Transitions:
  - RD_IDLE: on din_start, latch cfg and clear counters. Go to RD_WAIT if !din_buf_ready, else RD_LEFT when cfg==LEFT, else RD_NORMAL.
  - RD_WAIT: when din_buf_ready, go to RD_LEFT or RD_NORMAL as above.
  - RD_LEFT: on issue go to RD_NORMAL.
  - RD_NORMAL: on a data issue with cnt00 == final:
    - cfg==RIGH goes to RD_RIGH.
    - else if cnt01 == final, go to RD_DONE.
    - else cfg==LEFT goes to RD_LEFT.
    - else stay in RD_NORMAL.
  - RD_RIGH: on issue, go to RD_DONE if cnt01 == final, else RD_NORMAL.
  - RD_DONE: when (!dout_valid | din_pe_ready), pulse dout_done for one cycle and go to RD_IDLE.
- dout_rd_last is set on the pass-end issue of the final pass, i.e. the issue that moves the FSM into RD_DONE.
- Boundaries:
  - rd_cnt00_finalnum=0 gives 1 data beat per pass.
  - rd_cnt01_finalnum=0 gives a single pass.
  - din_start outside RD_IDLE is ignored.
  - A cfg change mid-operation has no effect.
  - A din_buf_ready drop after leaving RD_WAIT is ignored.

Test Plan:
- NORMAL, cnt00_final=3, cnt01_final=0, srad_final=15, pe_ready=1:
  - Expect cen on 4 consecutive cycles with addr 0,1,2,3.
  - Expect dout_valid 4 cycles, pad=0, rd_last on the 4th beat.
  - Expect dout_done 1 cycle after the last beat, then RD_IDLE.
- LEFT, cnt00_final=2, cnt01_final=1:
  - Expect beat sequence P,D0,D1,D2,P,D3,D4,D5 (addr 0..5).
  - Expect rd_last on D5 and done one pulse.
- RIGH, cnt00_final=1, cnt01_final=1:
  - Expect sequence D0,D1,P,D2,D3,P with rd_last on the final P.
  - Expect cen never asserted on pad beats.
- Backpressure: NORMAL, cnt00_final=3, pe_ready low for 3 cycles after the 2nd beat:
  - Expect dout_valid held, no cen while stalled, addr stays 2.
  - Expect no beat lost or duplicated; 4 beats total.
- Wrap and wait:
  - Start with buf_ready=0: expect RD_WAIT and no issue.
  - Raise buf_ready with srad_final=2 and 5 data beats: expect addr 0,1,2,0,1.
- Reset mid-pass (after 2 beats): expect next cycle dout_valid=0, state 0, counters 0, no dout_done.

Source files
------------

// File: rtl/ifr_cnt_fsm.sv
// ifr_cnt_fsm: read-side counter and FSM for the input-feature row buffer.
// Issues SRAM reads for the data beats of a row and inserts left/right
// zero-padding beats around them. The row is repeated for a programmed number
// of passes, and the beats go to the PE array over a valid/ready handshake.
// The SRAM has one cycle of read latency, so a beat issued with cen in cycle N
// is presented with dout_valid in cycle N+1. dout_pad tells the PE input mux to
// select zero instead of the SRAM data.
module ifr_cnt_fsm #(
  parameter int CNT00_WIDTH   = 10,
  parameter int CNT01_WIDTH   = 10,
  parameter int RS_ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din_start,
  input  logic                     din_buf_ready,
  input  logic [2:0]               din_cfg_mast_state,
  input  logic                     din_pe_ready,
  input  logic [CNT00_WIDTH-1:0]   rd_cnt00_finalnum,
  input  logic [CNT01_WIDTH-1:0]   rd_cnt01_finalnum,
  input  logic [RS_ADDR_WIDTH-1:0] rd_srad_finalnum,
  output logic [2:0]               dout_rd_curr_state,
  output logic                     dout_sram_cen,
  output logic [RS_ADDR_WIDTH-1:0] dout_sram_addr,
  output logic                     dout_valid,
  output logic                     dout_pad,
  output logic                     dout_rd_last,
  output logic [CNT00_WIDTH-1:0]   dout_rd_cnt00,
  output logic [CNT01_WIDTH-1:0]   dout_rd_cnt01,
  output logic                     dout_busy,
  output logic                     dout_done
);

  typedef enum logic [2:0] {
    RD_IDLE   = 3'd0,
    RD_NORMAL = 3'd1,
    RD_LEFT   = 3'd2,
    RD_RIGH   = 3'd3,
    RD_DONE   = 3'd4,
    RD_WAIT   = 3'd5
  } rd_state_t;

  // Padding mode of the current operation, captured at start.
  typedef enum logic [1:0] {
    CFG_NORMAL = 2'd0,
    CFG_LEFT   = 2'd1,
    CFG_RIGH   = 2'd2
  } cfg_t;

  localparam logic [CNT00_WIDTH-1:0]   CNT00_ONE = CNT00_WIDTH'(1);
  localparam logic [CNT01_WIDTH-1:0]   CNT01_ONE = CNT01_WIDTH'(1);
  localparam logic [RS_ADDR_WIDTH-1:0] SRAD_ONE  = RS_ADDR_WIDTH'(1);

  rd_state_t state;
  cfg_t      cfg_q;
  cfg_t      cfg_in;

  logic [CNT00_WIDTH-1:0]   cnt00;
  logic [CNT01_WIDTH-1:0]   cnt01;
  logic [RS_ADDR_WIDTH-1:0] srad;

  logic start_go;
  logic beat_slot;
  logic issue;
  logic data_issue;
  logic pad_issue;
  logic cnt00_at_final;
  logic cnt01_at_final;
  logic srad_at_final;
  logic pass_end;
  logic final_issue;

  // Decode the raw mode input; unused codes fall back to NORMAL.
  always_comb begin
    // NOTE: assign a default before the case so every path drives cfg_in and no latch is inferred.
    cfg_in = CFG_NORMAL;
    case (din_cfg_mast_state)
      3'd1:    cfg_in = CFG_LEFT;
      3'd3:    cfg_in = CFG_RIGH;
      default: cfg_in = CFG_NORMAL;
    endcase
  end

  // Start is honoured only from idle; anywhere else the pulse is ignored.
  assign start_go = (state == RD_IDLE) && din_start;

  // The output register can take a new beat when it is empty or is being drained.
  assign beat_slot = !dout_valid || din_pe_ready;

  // A beat is issued from any of the three streaming states when the slot is free.
  assign issue = beat_slot &&
                 ((state == RD_LEFT) || (state == RD_NORMAL) || (state == RD_RIGH));

  // Data beats come only from NORMAL. Pad beats never touch the SRAM.
  assign data_issue = issue && (state == RD_NORMAL);
  assign pad_issue  = issue && (state != RD_NORMAL);

  assign cnt00_at_final = (cnt00 == rd_cnt00_finalnum);
  assign cnt01_at_final = (cnt01 == rd_cnt01_finalnum);
  assign srad_at_final  = (srad  == rd_srad_finalnum);

  // A pass ends on its last data beat, or on the trailing pad beat in RIGH mode.
  assign pass_end = (data_issue && cnt00_at_final && (cfg_q != CFG_RIGH)) ||
                    (issue && (state == RD_RIGH));

  // The pass end of the final pass is the last beat of the whole operation.
  assign final_issue = pass_end && cnt01_at_final;

  // SRAM read enable is combinational so the data lines up with dout_valid.
  assign dout_sram_cen  = data_issue;
  assign dout_sram_addr = srad;

  assign dout_rd_curr_state = state;
  assign dout_rd_cnt00      = cnt00;
  assign dout_rd_cnt01      = cnt01;
  assign dout_busy          = (state != RD_IDLE);

  // Column, pass and SRAM address counters; all are cleared by reset and by start.
  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      cnt00 <= '0;
      cnt01 <= '0;
      srad  <= '0;
    end else begin
      if (data_issue) begin
        cnt00 <= cnt00_at_final ? '0 : cnt00 + CNT00_ONE;
        // The address runs on across passes; only start or reset rewinds it.
        srad  <= srad_at_final ? '0 : srad + SRAD_ONE;
      end
      if (pass_end) begin
        cnt01 <= cnt01 + CNT01_ONE;
      end
    end
  end

  // Read FSM together with its registered beat outputs and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RD_IDLE;
      cfg_q        <= CFG_NORMAL;
      dout_valid   <= 1'b0;
      dout_pad     <= 1'b0;
      dout_rd_last <= 1'b0;
      dout_done    <= 1'b0;
    end else begin
      dout_done <= 1'b0;

      // Output stage: load on issue, drain on accept, otherwise hold the stalled beat.
      if (issue) begin
        dout_valid   <= 1'b1;
        dout_pad     <= pad_issue;
        dout_rd_last <= final_issue;
      end else if (din_pe_ready) begin
        dout_valid <= 1'b0;
      end

      case (state)
        RD_IDLE: begin
          if (din_start) begin
            cfg_q <= cfg_in;
            if (!din_buf_ready) begin
              state <= RD_WAIT;
            end else if (cfg_in == CFG_LEFT) begin
              state <= RD_LEFT;
            end else begin
              state <= RD_NORMAL;
            end
          end
        end

        RD_WAIT: begin
          if (din_buf_ready) begin
            state <= (cfg_q == CFG_LEFT) ? RD_LEFT : RD_NORMAL;
          end
        end

        RD_LEFT: begin
          if (issue) begin
            state <= RD_NORMAL;
          end
        end

        RD_NORMAL: begin
          if (data_issue && cnt00_at_final) begin
            if (cfg_q == CFG_RIGH) begin
              state <= RD_RIGH;
            end else if (cnt01_at_final) begin
              state <= RD_DONE;
            end else if (cfg_q == CFG_LEFT) begin
              state <= RD_LEFT;
            end
          end
        end

        RD_RIGH: begin
          if (issue) begin
            state <= cnt01_at_final ? RD_DONE : RD_NORMAL;
          end
        end

        RD_DONE: begin
          // Finish only once the last beat has left the output register.
          if (beat_slot) begin
            dout_done <= 1'b1;
            state     <= RD_IDLE;
          end
        end

        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifr_cnt_fsm.sv
// tb_ifr_cnt_fsm: self-checking bench for ifr_cnt_fsm.
// For each operation the reference model lists the expected beat stream
// (pad/data, last flag) and the expected SRAM address sequence. It builds the
// list from the pass structure: an optional leading pad, n00+1 data beats and
// an optional trailing pad per pass. Observed cen/addr and accepted beats are
// compared against the list.
module tb_ifr_cnt_fsm;

  localparam int W00 = 10;
  localparam int W01 = 10;
  localparam int WAD = 10;

  logic           clk;
  logic           reset;
  logic           din_start;
  logic           din_buf_ready;
  logic [2:0]     din_cfg_mast_state;
  logic           din_pe_ready;
  logic [W00-1:0] rd_cnt00_finalnum;
  logic [W01-1:0] rd_cnt01_finalnum;
  logic [WAD-1:0] rd_srad_finalnum;
  logic [2:0]     dout_rd_curr_state;
  logic           dout_sram_cen;
  logic [WAD-1:0] dout_sram_addr;
  logic           dout_valid;
  logic           dout_pad;
  logic           dout_rd_last;
  logic [W00-1:0] dout_rd_cnt00;
  logic [W01-1:0] dout_rd_cnt01;
  logic           dout_busy;
  logic           dout_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic pad;
    logic last;
  } beat_t;

  ifr_cnt_fsm #(
    .CNT00_WIDTH  (W00),
    .CNT01_WIDTH  (W01),
    .RS_ADDR_WIDTH(WAD)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .din_start         (din_start),
    .din_buf_ready     (din_buf_ready),
    .din_cfg_mast_state(din_cfg_mast_state),
    .din_pe_ready      (din_pe_ready),
    .rd_cnt00_finalnum (rd_cnt00_finalnum),
    .rd_cnt01_finalnum (rd_cnt01_finalnum),
    .rd_srad_finalnum  (rd_srad_finalnum),
    .dout_rd_curr_state(dout_rd_curr_state),
    .dout_sram_cen     (dout_sram_cen),
    .dout_sram_addr    (dout_sram_addr),
    .dout_valid        (dout_valid),
    .dout_pad          (dout_pad),
    .dout_rd_last      (dout_rd_last),
    .dout_rd_cnt00     (dout_rd_cnt00),
    .dout_rd_cnt01     (dout_rd_cnt01),
    .dout_busy         (dout_busy),
    .dout_done         (dout_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Runs one operation. mode: 0 = PE always ready, 1 = random ready,
  // 2 = ready low for 3 cycles after the 2nd accepted beat.
  // late_buf starts with the buffer not ready; perturb toggles start/cfg/buf_ready while busy.
  task automatic run_op(input int cfg_code, input int n00, input int n01, input int sfin,
                        input int mode, input bit late_buf, input bit perturb);
    beat_t exp_beats[$];
    int    exp_addr[$];
    bit    is_left;
    bit    is_righ;
    int    data_idx;
    int    issued;
    int    accepted;
    int    stall_left;
    int    done_cnt;
    bit    done_seen;
    bit    stalled_prev;
    logic  pad_prev;
    logic  last_prev;
    beat_t b;

    // Reference model: the beat stream implied by the pass structure.
    is_left  = (cfg_code == 1);
    is_righ  = (cfg_code == 3);
    data_idx = 0;
    for (int p = 0; p <= n01; p++) begin
      if (is_left) exp_beats.push_back('{pad: 1'b1, last: 1'b0});
      for (int c = 0; c <= n00; c++) begin
        exp_beats.push_back('{pad: 1'b0, last: 1'b0});
        exp_addr.push_back(data_idx % (sfin + 1));
        data_idx++;
      end
      if (is_righ) exp_beats.push_back('{pad: 1'b1, last: 1'b0});
    end
    exp_beats[exp_beats.size() - 1].last = 1'b1;

    @(negedge clk);
    din_cfg_mast_state = 3'(cfg_code);
    rd_cnt00_finalnum  = W00'(n00);
    rd_cnt01_finalnum  = W01'(n01);
    rd_srad_finalnum   = WAD'(sfin);
    din_buf_ready      = !late_buf;
    din_pe_ready       = 1'b1;
    din_start          = 1'b1;
    @(negedge clk);
    din_start = 1'b0;

    if (late_buf) begin
      for (int k = 0; k < 3; k++) begin
        #1;
        check("wait_state", 32'(dout_rd_curr_state), 32'd5);
        check("wait_no_cen", 32'(dout_sram_cen), 32'd0);
        check("wait_no_valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
      end
      din_buf_ready = 1'b1;
      @(negedge clk);
    end

    issued       = 0;
    accepted     = 0;
    stall_left   = 0;
    done_cnt     = 0;
    done_seen    = 1'b0;
    stalled_prev = 1'b0;
    pad_prev     = 1'b0;
    last_prev    = 1'b0;

    for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
      case (mode)
        1: din_pe_ready = ($urandom_range(0, 3) != 0);
        2: begin
          din_pe_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: din_pe_ready = 1'b1;
      endcase
      if (perturb && dout_busy) begin
        din_start          = ($urandom_range(0, 3) == 0);
        din_cfg_mast_state = 3'($urandom_range(0, 7));
        din_buf_ready      = $urandom_range(0, 1) != 0;
      end else begin
        din_start = 1'b0;
      end
      #1;

      if (stalled_prev) begin
        check("stall_hold_valid", 32'(dout_valid), 32'd1);
        check("stall_hold_pad", 32'(dout_pad), 32'(pad_prev));
        check("stall_hold_last", 32'(dout_rd_last), 32'(last_prev));
      end
      if (dout_valid && !din_pe_ready) check("stall_no_cen", 32'(dout_sram_cen), 32'd0);
      check("srad_track", 32'(dout_sram_addr), 32'(issued % (sfin + 1)));

      if (dout_sram_cen) begin
        if (exp_addr.size() == 0) begin
          check("extra_cen", 32'd1, 32'd0);
        end else begin
          check("cen_addr", 32'(dout_sram_addr), 32'(exp_addr.pop_front()));
        end
        check("cnt00_at_issue", 32'(dout_rd_cnt00), 32'(issued % (n00 + 1)));
        issued++;
      end

      if (dout_valid && din_pe_ready) begin
        if (exp_beats.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          b = exp_beats.pop_front();
          check("beat_pad", 32'(dout_pad), 32'(b.pad));
          check("beat_last", 32'(dout_rd_last), 32'(b.last));
        end
        accepted++;
        if (mode == 2 && accepted == 2) stall_left = 3;
      end

      if (dout_done) begin
        done_seen = 1'b1;
        done_cnt++;
        check("done_all_beats", 32'(exp_beats.size()), 32'd0);
        check("done_all_reads", 32'(exp_addr.size()), 32'd0);
      end

      stalled_prev = dout_valid && !din_pe_ready;
      pad_prev     = dout_pad;
      last_prev    = dout_rd_last;
      @(negedge clk);
    end

    check("op_completed", 32'(done_seen), 32'd1);
    din_start     = 1'b0;
    din_pe_ready  = 1'b1;
    din_buf_ready = 1'b1;
    #1;
    check("done_single_pulse", 32'(dout_done), 32'd0);
    check("idle_state", 32'(dout_rd_curr_state), 32'd0);
    check("idle_busy", 32'(dout_busy), 32'd0);
    check("idle_valid", 32'(dout_valid), 32'd0);
    check("end_cnt00", 32'(dout_rd_cnt00), 32'd0);
    check("end_cnt01", 32'(dout_rd_cnt01), 32'((n01 + 1) % (1 << W01)));
    check("done_count", 32'(done_cnt), 32'd1);
  endtask

  int acc;

  initial begin
    reset              = 1'b1;
    din_start          = 1'b0;
    din_buf_ready      = 1'b1;
    din_cfg_mast_state = 3'd2;
    din_pe_ready       = 1'b1;
    rd_cnt00_finalnum  = '0;
    rd_cnt01_finalnum  = '0;
    rd_srad_finalnum   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", 32'(dout_rd_curr_state), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_pad", 32'(dout_pad), 32'd0);
    check("rst_last", 32'(dout_rd_last), 32'd0);
    check("rst_done", 32'(dout_done), 32'd0);
    check("rst_busy", 32'(dout_busy), 32'd0);
    check("rst_cnt00", 32'(dout_rd_cnt00), 32'd0);
    check("rst_cnt01", 32'(dout_rd_cnt01), 32'd0);
    check("rst_addr", 32'(dout_sram_addr), 32'd0);
    check("rst_cen", 32'(dout_sram_cen), 32'd0);

    // Directed plan: NORMAL, LEFT, RIGH, backpressure, wait + address wrap.
    run_op(2, 3, 0, 15, 0, 1'b0, 1'b0);
    run_op(1, 2, 1, 15, 0, 1'b0, 1'b0);
    run_op(3, 1, 1, 15, 0, 1'b0, 1'b0);
    run_op(2, 3, 0, 15, 2, 1'b0, 1'b0);
    run_op(2, 4, 0, 2, 0, 1'b1, 1'b0);

    // Boundaries: one data beat per pass, single pass, unused cfg code.
    run_op(2, 0, 0, 15, 0, 1'b0, 1'b0);
    run_op(1, 0, 2, 3, 0, 1'b0, 1'b0);
    run_op(3, 0, 0, 0, 1, 1'b0, 1'b0);
    run_op(6, 2, 1, 1, 2, 1'b1, 1'b0);

    // Randomized operations with random backpressure and ignored mid-run inputs.
    for (int r = 0; r < 24; r++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
             $urandom_range(0, 3) == 0, 1'b1);
    end

    // Reset in the middle of a pass, after two accepted beats.
    @(negedge clk);
    din_cfg_mast_state = 3'd2;
    rd_cnt00_finalnum  = W00'(7);
    rd_cnt01_finalnum  = W01'(0);
    rd_srad_finalnum   = WAD'(15);
    din_buf_ready      = 1'b1;
    din_pe_ready       = 1'b1;
    din_start          = 1'b1;
    @(negedge clk);
    din_start = 1'b0;
    acc = 0;
    for (int k = 0; k < 20 && acc < 2; k++) begin
      #1;
      if (dout_valid && din_pe_ready) acc++;
      @(negedge clk);
    end
    check("mid_reset_reached", 32'(acc), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_reset_valid", 32'(dout_valid), 32'd0);
    check("mid_reset_state", 32'(dout_rd_curr_state), 32'd0);
    check("mid_reset_cnt00", 32'(dout_rd_cnt00), 32'd0);
    check("mid_reset_cnt01", 32'(dout_rd_cnt01), 32'd0);
    check("mid_reset_addr", 32'(dout_sram_addr), 32'd0);
    check("mid_reset_done", 32'(dout_done), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("post_reset_quiet_valid", 32'(dout_valid), 32'd0);
      check("post_reset_quiet_cen", 32'(dout_sram_cen), 32'd0);
      check("post_reset_quiet_done", 32'(dout_done), 32'd0);
    end

    // A normal operation still completes after the abort.
    run_op(1, 1, 1, 2, 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
